c_fun: RTL and testbench
========================

Name: c_fun

Overview:
- Computes the Keccak-f[1600] theta column parities C[x] = A[x,0]^A[x,1]^A[x,2]^A[x,3]^A[x,4] for x=0..4 over a full 1600-bit state.
- First stage of the SHA3-512 round datapath; its output feeds the dFun stage (theta D computation).
- Output is registered with a one-cycle valid pipeline.

Parameters:
- LANE_W, 64, lane width in bits. State width is 25*LANE_W and output width is 5*LANE_W. Only 64 is required to be supported; other values are a generic elaboration.

Ports:
- inClk  input  1  clock, rising-edge active.
- inRstN  input  1  asynchronous active-low reset.
- inValid  input  1  inData is valid this cycle.
- inData  input  25*LANE_W  Keccak state. Lane (x,y) occupies bits [LANE_W*(x+5y) +: LANE_W], with x,y in 0..4.
- outValid  output  1  outData holds a fresh result.
- outData  output  5*LANE_W  column parities. C[x] occupies bits [LANE_W*x +: LANE_W].

Behaviour:
- Reset: asynchronous assert on inRstN=0 clears outData to all-zero and outValid to 0. Release is synchronous to inClk.
- Parity: C[x] is the bitwise XOR of the five lanes of column x. No rotation or carry; bit i of C[x] depends only on bit i of lanes (x,0)..(x,4).
- Latency: exactly 1 cycle.
  - If inValid=1 at a rising edge, outData takes C(inData) and outValid goes to 1 at that edge.
  - If inValid=0, outValid goes to 0 and outData holds its last value.
- Throughput: one state per cycle. Back-to-back inValid is fully supported, and each output corresponds to the input of the previous cycle.
- No backpressure: the consumer must accept outData in the cycle outValid=1.
- Reset mid-operation: an in-flight result is discarded, and outValid=0 immediately (asynchronously).
- X-free: while inRstN=0, outputs stay at reset values regardless of inValid or inData.

Optional Feature:
- Macro: CFUN_D_OUT_EN.
- Defined:
  - Extra output port outD (5*LANE_W), registered alongside outData with the same valid timing.
  - D[x] = C[(x+4) mod 5] ^ ROTL1(C[(x+1) mod 5]), where ROTL1 is a left rotate by 1 within the lane.
  - outD resets to 0.
- Not defined: port outD is absent and no D logic is generated.

Decomposition:
- Shared package keccak_pkg holds:
  - LANE_W = 64, STATE_W = 1600, NUM_X = 5, NUM_Y = 5;
  - the lane_t typedef (LANE_W-bit vector);
  - a lane-offset function returning LANE_W*(x+5y).
- One natural sub-module: c_fun_col, a combinational 5-input lane XOR instantiated five times (one per column x).
- Registers and the optional D logic stay in c_fun.

Test Plan:
- Reset: hold inRstN=0 with random inData and inValid=1 -> outData=0, outValid=0. Assert inRstN mid-stream -> outValid drops without waiting for a clock edge.
- SHA3-512 padded block:
  - Stimulus: lane0=0x00000001997B5853, lane8 (x=3,y=1)=0x8000000000000000, other lanes 0, inValid=1 for one cycle.
  - Response next cycle: C0=0x00000001997B5853, C3=0x8000000000000000, C1=C2=C4=0, outValid=1 for one cycle.
- Column cancellation: lanes (2,0)..(2,3)=0xFFFFFFFFFFFFFFFF, (2,4)=0 -> C2=0. Then set (2,4)=0x1 -> C2=0x0000000000000001.
- Column isolation: walking single-bit pattern, setting bit i of lane (x,y) for every x, y and i=0,63 -> only bit i of C[x] set, all other outData bits 0.
- Streaming: 8 back-to-back random states with inValid=1, then inValid=0 -> each output matches the software XOR model one cycle later. Afterwards outValid=0 and outData holds the last result.
- With CFUN_D_OUT_EN:
  - Stimulus: C0=0x1, C1=0x8000000000000000 (via lane0=0x1, lane1=0x8000000000000000).
  - Response: D0=C4^ROTL1(C1)=0x1, D1=C0^ROTL1(C2)=0x1, D2=C1^ROTL1(C3)=0x8000000000000000, D3=0, D4=C3^ROTL1(C0)=0x2.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, lane type and lane addressing helper.
// Used by c_fun and its column sub-module.
package keccak_pkg;
   localparam int LANE_W  = 64;
   localparam int STATE_W = 1600;
   localparam int NUM_X   = 5;
   localparam int NUM_Y   = 5;

   typedef logic [LANE_W-1:0] lane_t;

   function automatic int lane_off(
      input int x,
      input int y,
      input int w = LANE_W
   );
      return w * (x + 5 * y);
   endfunction
endpackage

// File: rtl/c_fun_col.sv
// One theta column: bitwise XOR of the five lanes of a column.
// Purely combinational; instantiated once per column by c_fun.
module c_fun_col #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a0,
   input  logic [W-1:0] i_a1,
   input  logic [W-1:0] i_a2,
   input  logic [W-1:0] i_a3,
   input  logic [W-1:0] i_a4,
   output logic [W-1:0] o_c
);
   assign o_c = i_a0 ^ i_a1 ^ i_a2 ^ i_a3 ^ i_a4;
endmodule

// File: rtl/c_fun.sv
// Keccak theta column parities C[x], registered with a 1-cycle valid.
// Define CFUN_D_OUT_EN to also register the theta D[x] lanes on outD.
module c_fun
   import keccak_pkg::*;
#(
   parameter int LANE_W = keccak_pkg::LANE_W
) (
   input  logic                  inClk,
   input  logic                  inRstN,
   input  logic                  inValid,
   input  logic [25*LANE_W-1:0]  inData,
   output logic                  outValid,
`ifdef CFUN_D_OUT_EN
   output logic [5*LANE_W-1:0]   outData,
   output logic [5*LANE_W-1:0]   outD
`else
   output logic [5*LANE_W-1:0]   outData
`endif
);
   logic [5*LANE_W-1:0] w_c;
   logic [5*LANE_W-1:0] r_c;
   logic                r_valid;

   for (genvar x = 0; x < NUM_X; x++) begin : g_col
      c_fun_col #(.W(LANE_W)) u_col (
         .i_a0 (inData[lane_off(x, 0, LANE_W) +: LANE_W]),
         .i_a1 (inData[lane_off(x, 1, LANE_W) +: LANE_W]),
         .i_a2 (inData[lane_off(x, 2, LANE_W) +: LANE_W]),
         .i_a3 (inData[lane_off(x, 3, LANE_W) +: LANE_W]),
         .i_a4 (inData[lane_off(x, 4, LANE_W) +: LANE_W]),
         .o_c  (w_c[LANE_W*x +: LANE_W])
      );
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         r_valid <= 1'b0;
         r_c     <= '0;
      end else begin
         r_valid <= inValid;
         if (inValid) r_c <= w_c;
      end
   end

   assign outValid = r_valid;
   assign outData  = r_c;

`ifdef CFUN_D_OUT_EN
   logic [5*LANE_W-1:0] w_d;
   logic [5*LANE_W-1:0] r_d;

   // D[x] = C[x-1] ^ rotl1(C[x+1]), indices mod 5
   for (genvar x = 0; x < NUM_X; x++) begin : g_d
      localparam int XM = (x + 4) % 5;
      localparam int XP = (x + 1) % 5;
      logic [LANE_W-1:0] w_cp;
      assign w_cp = w_c[LANE_W*XP +: LANE_W];
      assign w_d[LANE_W*x +: LANE_W] = w_c[LANE_W*XM +: LANE_W]
         ^ {w_cp[LANE_W-2:0], w_cp[LANE_W-1]};
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         r_d <= '0;
      end else if (inValid) begin
         r_d <= w_d;
      end
   end

   assign outD = r_d;
`endif
endmodule

// File: tb/tb_c_fun.sv
// Directed/table-driven bench for c_fun (theta column parities).
// Exercises outD too when CFUN_D_OUT_EN is defined.
module tb_c_fun;
   logic          inClk = 1'b0;
   logic          inRstN;
   logic          inValid;
   logic [1599:0] inData;
   logic          outValid;
   logic [319:0]  outData;
`ifdef CFUN_D_OUT_EN
   logic [319:0]  outD;
`endif

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string         nm;
      logic [1599:0] data;
      logic [319:0]  exp;
   } vec_t;

   vec_t vecs[$];

   c_fun dut (
      .inClk    (inClk),
      .inRstN   (inRstN),
      .inValid  (inValid),
      .inData   (inData),
      .outValid (outValid),
`ifdef CFUN_D_OUT_EN
      .outData  (outData),
      .outD     (outD)
`else
      .outData  (outData)
`endif
   );

   always #5 inClk = ~inClk;

   task automatic chk(input string nm, input logic [319:0] act,
                      input logic [319:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [1599:0] set_lane(input logic [1599:0] s,
      input int x, input int y, input logic [63:0] v);
      logic [1599:0] r;
      r = s;
      r[64*(x+5*y) +: 64] = v;
      return r;
   endfunction

   function automatic logic [1599:0] rnd_state();
      logic [1599:0] r;
      for (int k = 0; k < 50; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // Reference: fold the five rows of each column
   function automatic logic [319:0] model(input logic [1599:0] s);
      logic [319:0] c;
      c = '0;
      for (int y = 0; y < 5; y++) c ^= s[320*y +: 320];
      return c;
   endfunction

   logic [1599:0] st;
   logic [319:0]  e;
   logic [1599:0] strm[8];

   initial begin
      inRstN  = 1'b0;
      inValid = 1'b1;
      inData  = rnd_state();

      // Reset held with live inputs
      repeat (3) begin
         @(negedge inClk);
         inData = rnd_state();
      end
      chk("rst_valid", {319'd0, outValid}, 320'd0);
      chk("rst_data", outData, 320'd0);
`ifdef CFUN_D_OUT_EN
      chk("rst_d", outD, 320'd0);
`endif
      inValid = 1'b0;
      inRstN  = 1'b1;

      // Vector table
      st = '0;
      st = set_lane(st, 0, 0, 64'h00000001997B5853);
      st = set_lane(st, 3, 1, 64'h8000000000000000);
      e = '0;
      e[0 +: 64]   = 64'h00000001997B5853;
      e[192 +: 64] = 64'h8000000000000000;
      vecs.push_back('{"sha3_pad", st, e});

      st = '0;
      for (int y = 0; y < 4; y++) st = set_lane(st, 2, y, '1);
      vecs.push_back('{"cancel", st, 320'd0});
      st = set_lane(st, 2, 4, 64'h1);
      e = '0;
      e[128] = 1'b1;
      vecs.push_back('{"cancel_1", st, e});

      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            for (int b = 0; b < 2; b++) begin
               int i;
               i = b ? 63 : 0;
               st = '0;
               st[64*(x+5*y) + i] = 1'b1;
               e = '0;
               e[64*x + i] = 1'b1;
               vecs.push_back('{$sformatf("walk_x%0d_y%0d_b%0d", x, y, i),
                                st, e});
            end

      foreach (vecs[k]) begin
         @(negedge inClk);
         inData  = vecs[k].data;
         inValid = 1'b1;
         @(negedge inClk);
         inValid = 1'b0;
         chk({vecs[k].nm, "_v"}, {319'd0, outValid}, 320'd1);
         chk(vecs[k].nm, outData, vecs[k].exp);
         inData = rnd_state();
         @(negedge inClk);
         chk({vecs[k].nm, "_v0"}, {319'd0, outValid}, 320'd0);
         chk({vecs[k].nm, "_hold"}, outData, vecs[k].exp);
      end

      // Streaming, back to back
      for (int k = 0; k < 8; k++) strm[k] = rnd_state();
      @(negedge inClk);
      inValid = 1'b1;
      inData  = strm[0];
      for (int k = 1; k < 8; k++) begin
         @(negedge inClk);
         chk($sformatf("strm%0d_v", k-1), {319'd0, outValid}, 320'd1);
         chk($sformatf("strm%0d", k-1), outData, model(strm[k-1]));
         inData = strm[k];
      end
      @(negedge inClk);
      inValid = 1'b0;
      inData  = rnd_state();
      chk("strm7_v", {319'd0, outValid}, 320'd1);
      chk("strm7", outData, model(strm[7]));
      repeat (2) @(negedge inClk);
      chk("strm_idle_v", {319'd0, outValid}, 320'd0);
      chk("strm_idle_hold", outData, model(strm[7]));

`ifdef CFUN_D_OUT_EN
      st = '0;
      st = set_lane(st, 0, 0, 64'h1);
      st = set_lane(st, 1, 0, 64'h8000000000000000);
      @(negedge inClk);
      inData  = st;
      inValid = 1'b1;
      @(negedge inClk);
      inValid = 1'b0;
      e = '0;
      e[0 +: 64]   = 64'h1;
      e[64 +: 64]  = 64'h1;
      e[128 +: 64] = 64'h8000000000000000;
      e[256 +: 64] = 64'h2;
      chk("d_out", outD, e);
      e = '0;
      e[0 +: 64]  = 64'h1;
      e[64 +: 64] = 64'h8000000000000000;
      chk("d_c", outData, e);
`endif

      // Asynchronous reset mid-stream
      @(negedge inClk);
      inData  = vecs[0].data;
      inValid = 1'b1;
      @(posedge inClk);
      #2;
      chk("mid_pre_v", {319'd0, outValid}, 320'd1);
      inRstN = 1'b0;
      #1;
      chk("mid_rst_v", {319'd0, outValid}, 320'd0);
      chk("mid_rst_data", outData, 320'd0);
      @(negedge inClk);
      inValid = 1'b0;
      inRstN  = 1'b1;
      @(negedge inClk);
      chk("post_rst_v", {319'd0, outValid}, 320'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
